// File: rtl/nas_vram_arb.sv
`default_nettype none
// ============================================================================
// Module      : nas_vram_arb
// Description : NASCOM 1 video RAM arbiter. The video fetch engine has
//               priority; the Z80 is held off with WAIT, and a starvation
//               counter lets it win once it has waited long enough.
// Revision    : 1.0 - initial release
// ============================================================================
module nas_vram_arb #(
    parameter int MAX_WAIT = 6,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vdusel_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    output logic          wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic [7:0]    vid_q,
    output logic          vid_ack,
    output logic          vid_ovf,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    output logic          ram_we,
    input  logic [7:0]    ram_q
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VRD  = 3'd1,
        S_VCAP = 3'd2,
        S_CRD  = 3'd3,
        S_CCAP = 3'd4,
        S_CWR  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_vid_pend;
    logic [AW-1:0] r_vid_addr;
    logic          r_cpu_pend;
    logic          r_cpu_done;
    logic          r_cpu_wr;
    logic [AW-1:0] r_cpu_addr;
    logic [7:0]    r_cpu_data;
    logic [3:0]    r_starve_cnt;

    logic [7:0]    r_cpu_q;
    logic          r_wait_n;
    logic [7:0]    r_vid_q;
    logic          r_vid_ack;
    logic          r_vid_ovf;
    logic [AW-1:0] r_ram_a;
    logic [7:0]    r_ram_d;
    logic          r_ram_we;

    logic          w_cpu_act;
    logic          w_cpu_win;
    logic          w_cpu_busy;
    logic          w_cpu_grant;
    logic          w_cpu_complete;

    assign w_cpu_act      = !vdusel_n && (!rd_n || !wr_n);
    assign w_cpu_win      = r_cpu_pend && (r_starve_cnt >= c_max_wait);
    assign w_cpu_busy     = (r_state == S_CRD) || (r_state == S_CCAP) || (r_state == S_CWR);
    assign w_cpu_grant    = (r_state == S_IDLE) && ((w_state_nxt == S_CRD) || (w_state_nxt == S_CWR));
    assign w_cpu_complete = (r_state == S_CCAP) || (r_state == S_CWR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_vid_pend && !w_cpu_win)
                    w_state_nxt = S_VRD;
                else if (r_cpu_pend && !r_cpu_wr)
                    w_state_nxt = S_CRD;
                else if (r_cpu_pend)
                    w_state_nxt = S_CWR;
            end
            S_VRD:   w_state_nxt = S_VCAP;
            S_VCAP:  w_state_nxt = S_IDLE;
            S_CRD:   w_state_nxt = S_CCAP;
            S_CCAP:  w_state_nxt = S_IDLE;
            S_CWR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_vid_pend   <= 1'b0;
            r_vid_addr   <= '0;
            r_cpu_pend   <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_cpu_wr     <= 1'b0;
            r_cpu_addr   <= '0;
            r_cpu_data   <= '0;
            r_starve_cnt <= '0;
            r_cpu_q      <= '0;
            r_wait_n     <= 1'b1;
            r_vid_q      <= '0;
            r_vid_ack    <= 1'b0;
            r_vid_ovf    <= 1'b0;
            r_ram_a      <= '0;
            r_ram_d      <= '0;
            r_ram_we     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vid_ack <= 1'b0;
            r_ram_we  <= 1'b0;

            // A request landing while one is still pending overwrites the address.
            if (vid_req) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= vid_a;
                if (r_vid_pend)
                    r_vid_ovf <= 1'b1;
            end else if (r_state == S_VRD) begin
                r_vid_pend <= 1'b0;
            end

            // RAM address is registered on grant so ram_q is ready in the CAP cycle.
            if (r_state == S_IDLE && w_state_nxt == S_VRD)
                r_ram_a <= vid_req ? vid_a : r_vid_addr;
            if (w_cpu_grant)
                r_ram_a <= r_cpu_addr;
            if (r_state == S_IDLE && w_state_nxt == S_CWR) begin
                r_ram_d  <= r_cpu_data;
                r_ram_we <= 1'b1;
            end

            if (r_state == S_VCAP) begin
                r_vid_q   <= ram_q;
                r_vid_ack <= 1'b1;
            end
            if (r_state == S_CCAP)
                r_cpu_q <= ram_q;

            if (w_cpu_act && !r_cpu_done && !r_cpu_pend) begin
                r_cpu_pend <= 1'b1;
                r_cpu_addr <= cpu_a;
                r_cpu_data <= cpu_d;
                r_cpu_wr   <= !wr_n;
                r_wait_n   <= 1'b0;
            end else if (w_cpu_complete) begin
                r_cpu_pend <= 1'b0;
                r_wait_n   <= 1'b1;
            end

            if (w_cpu_complete)
                r_cpu_done <= 1'b1;
            else if (!w_cpu_act)
                r_cpu_done <= 1'b0;

            if (w_cpu_grant)
                r_starve_cnt <= '0;
            else if (r_cpu_pend && !w_cpu_busy && r_starve_cnt != 4'hF)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign cpu_q   = r_cpu_q;
    assign wait_n  = r_wait_n;
    assign vid_q   = r_vid_q;
    assign vid_ack = r_vid_ack;
    assign vid_ovf = r_vid_ovf;
    assign ram_a   = r_ram_a;
    assign ram_d   = r_ram_d;
    assign ram_we  = r_ram_we;

endmodule
`default_nettype wire

// File: tb/tb_nas_vram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_nas_vram_arb
// Description : Directed bench for nas_vram_arb with a synchronous VRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nas_vram_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vdusel_n, rd_n, wr_n;
    logic [9:0] cpu_a;
    logic [7:0] cpu_d;
    logic [7:0] cpu_q;
    logic       wait_n;
    logic       vid_req;
    logic [9:0] vid_a;
    logic [7:0] vid_q;
    logic       vid_ack, vid_ovf;
    logic [9:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_we;
    logic [7:0] ram_q;

    logic       poke_en;
    logic [9:0] poke_a;
    logic [7:0] poke_d;
    logic [7:0] mem [0:1023];
    int         we_cnt  = 0;
    int         ack_cnt = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nas_vram_arb #(.MAX_WAIT(6), .AW(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .vdusel_n(vdusel_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q), .wait_n(wait_n),
        .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q),
        .vid_ack(vid_ack), .vid_ovf(vid_ovf),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    // Synchronous VRAM: data for ram_a appears the cycle after
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a] <= ram_d;
            we_cnt     <= we_cnt + 1;
        end
        if (poke_en)
            mem[poke_a] <= poke_d;
        ram_q <= mem[ram_a];
        if (vid_ack)
            ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base_ack;
        int low_cnt;

        reset_n  = 1'b0;
        vdusel_n = 1'b0;
        rd_n     = 1'b1;
        wr_n     = 1'b0;
        cpu_a    = 10'h2AA;
        cpu_d    = 8'hC3;
        vid_req  = 1'b0;
        vid_a    = '0;
        poke_en  = 1'b0;
        poke_a   = '0;
        poke_d   = '0;

        // Reset held with a write strobe active; preload VRAM meanwhile
        poke(10'h3FF, 8'h41);
        poke(10'h200, 8'hA5);
        poke(10'h300, 8'h11);
        poke(10'h301, 8'h22);
        poke(10'h302, 8'h33);
        poke(10'h010, 8'hE0);
        poke(10'h011, 8'hE1);
        check("rst_wait_n",  wait_n,  1);
        check("rst_cpu_q",   cpu_q,   0);
        check("rst_vid_q",   vid_q,   0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_vid_ovf", vid_ovf, 0);
        check("rst_ram_a",   ram_a,   0);
        check("rst_ram_d",   ram_d,   0);
        check("rst_ram_we",  ram_we,  0);
        check("rst_we_cnt",  we_cnt,  0);

        reset_n = 1'b1;
        tick();
        check("rw_wait_lo",  wait_n, 0);
        check("rw_we_idle",  ram_we, 0);
        tick();
        check("rw_we",       ram_we, 1);
        check("rw_ram_a",    ram_a,  10'h2AA);
        check("rw_ram_d",    ram_d,  8'hC3);
        check("rw_wait_lo2", wait_n, 0);
        vdusel_n = 1'b1;
        wr_n     = 1'b1;
        tick();
        check("rw_wait_hi",  wait_n, 1);
        check("rw_we_off",   ram_we, 0);
        tick();
        check("rw_mem",      mem[10'h2AA], 8'hC3);
        check("rw_we_cnt",   we_cnt, 1);

        // Video fetch alone
        vid_req = 1'b1;
        vid_a   = 10'h3FF;
        tick();
        vid_req = 1'b0;
        check("v_ack0",   vid_ack, 0);
        tick();
        check("v_ram_a",  ram_a, 10'h3FF);
        tick();
        check("v_ack1",   vid_ack, 0);
        tick();
        check("v_ack",    vid_ack, 1);
        check("v_q",      vid_q,   8'h41);
        tick();
        check("v_ack_end", vid_ack, 0);
        check("v_ovf",    vid_ovf, 0);

        // CPU write 0x55 -> 0x123
        vdusel_n = 1'b0;
        wr_n     = 1'b0;
        cpu_a    = 10'h123;
        cpu_d    = 8'h55;
        tick();
        check("cw_wait0", wait_n, 0);
        tick();
        check("cw_wait1", wait_n, 0);
        check("cw_we",    ram_we, 1);
        check("cw_ram_a", ram_a,  10'h123);
        check("cw_ram_d", ram_d,  8'h55);
        tick();
        check("cw_wait_hi", wait_n, 1);
        check("cw_we_off",  ram_we, 0);
        check("cw_we_cnt",  we_cnt, 2);
        vdusel_n = 1'b1;
        wr_n     = 1'b1;
        tick();

        // CPU read of 0x123
        vdusel_n = 1'b0;
        rd_n     = 1'b0;
        tick();
        check("cr_wait0", wait_n, 0);
        tick();
        check("cr_wait1", wait_n, 0);
        check("cr_ram_a", ram_a,  10'h123);
        tick();
        check("cr_wait2", wait_n, 0);
        tick();
        check("cr_wait_hi", wait_n, 1);
        check("cr_q",       cpu_q,  8'h55);

        // Strobe held after release: no second access even though RAM changes
        low_cnt = 0;
        poke(10'h123, 8'h99);
        if (wait_n !== 1'b1) low_cnt++;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (wait_n !== 1'b1) low_cnt++;
        end
        check("hold_wait_low", low_cnt, 0);
        check("hold_cpu_q",    cpu_q,   8'h55);
        vdusel_n = 1'b1;
        rd_n     = 1'b1;
        tick();
        vdusel_n = 1'b0;
        rd_n     = 1'b0;
        tick();
        check("fresh_wait0", wait_n, 0);
        tick();
        tick();
        tick();
        check("fresh_wait_hi", wait_n, 1);
        check("fresh_q",       cpu_q,  8'h99);
        vdusel_n = 1'b1;
        rd_n     = 1'b1;
        tick();

        // Contention: video every 3 cycles against a pending CPU read
        vdusel_n = 1'b0;
        rd_n     = 1'b0;
        cpu_a    = 10'h200;
        vid_req  = 1'b1;
        vid_a    = 10'h300;
        tick();                                   // E1
        vid_req = 1'b0;
        check("ct_wait_e1", wait_n, 0);
        tick();                                   // E2
        check("ct_ram_a_e2", ram_a, 10'h300);
        tick();                                   // E3
        vid_req = 1'b1;
        vid_a   = 10'h301;
        tick();                                   // E4
        vid_req = 1'b0;
        check("ct_ack_e4", vid_ack, 1);
        check("ct_vq_e4",  vid_q,   8'h11);
        tick();                                   // E5
        check("ct_ram_a_e5", ram_a, 10'h301);
        tick();                                   // E6
        vid_req = 1'b1;
        vid_a   = 10'h302;
        tick();                                   // E7
        vid_req = 1'b0;
        check("ct_ack_e7",  vid_ack, 1);
        check("ct_vq_e7",   vid_q,   8'h22);
        check("ct_wait_e7", wait_n,  0);
        tick();                                   // E8
        check("ct_grant_a", ram_a,   10'h200);
        tick();                                   // E9
        check("ct_wait_e9", wait_n,  0);
        tick();                                   // E10
        check("ct_wait_e10", wait_n, 1);
        check("ct_cpu_q",    cpu_q,  8'hA5);
        vdusel_n = 1'b1;
        rd_n     = 1'b1;
        tick();                                   // E11
        check("ct_ram_a_e11", ram_a, 10'h302);
        tick();
        tick();                                   // E13
        check("ct_ack_e13", vid_ack, 1);
        check("ct_vq_e13",  vid_q,   8'h33);
        check("ct_ovf",     vid_ovf, 0);
        tick();

        // Overrun: two requests one cycle apart
        base_ack = ack_cnt;
        vid_req  = 1'b1;
        vid_a    = 10'h010;
        tick();
        vid_a    = 10'h011;
        tick();
        vid_req  = 1'b0;
        check("ov_flag",  vid_ovf, 1);
        check("ov_ram_a", ram_a,   10'h011);
        tick();
        tick();
        check("ov_ack",   vid_ack, 1);
        check("ov_vq",    vid_q,   8'hE1);
        for (int i = 0; i < 6; i++) tick();
        check("ov_ack_cnt", ack_cnt - base_ack, 1);
        check("ov_sticky",  vid_ovf, 1);

        reset_n = 1'b0;
        tick();
        check("rst2_ovf",  vid_ovf, 0);
        check("rst2_vq",   vid_q,   0);
        check("rst2_cq",   cpu_q,   0);
        check("rst2_wait", wait_n,  1);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nas_vram_arb.md
Name: nas_vram_arb

Overview:
Arbiter for the NASCOM 1 1Kx8 video RAM, shared between the Z80 (via vdusel_n/rd_n/wr_n) and the video character-fetch engine.
- Video fetches have priority, so normal CPU accesses never cause display snow.
- The CPU is held off with wait_n until it gets a slot.
- A starvation counter bounds CPU latency: once it reaches the bound, the CPU wins over a pending video fetch.
- Sits between nas1_vid's scan counters and the VRAM macro; runs on the 16MHz video clock.

Parameters:
MAX_WAIT, 6, CPU-pending cycles after which the CPU wins arbitration over a pending video fetch (1..15)
AW, 10, VRAM address width

Ports:
clk  in  1  16MHz video/system clock
reset_n  in  1  synchronous active-low reset
vdusel_n  in  1  CPU select of video RAM, active low, decoded externally
rd_n  in  1  CPU read strobe, active low
wr_n  in  1  CPU write strobe, active low
cpu_a  in  AW  CPU address (low bits)
cpu_d  in  8  CPU write data
cpu_q  out  8  CPU read data, held until next CPU read completes
wait_n  out  1  to Z80 WAIT, active low
vid_req  in  1  one-cycle fetch request from scan logic
vid_a  in  AW  fetch address, valid with vid_req
vid_q  out  8  fetched character
vid_ack  out  1  one-cycle pulse, vid_q valid
vid_ovf  out  1  sticky: vid_req arrived while previous fetch still pending
ram_a  out  AW  VRAM address
ram_d  out  8  VRAM write data
ram_we  out  1  VRAM write enable
ram_q  in  8  VRAM read data, synchronous RAM, valid the cycle after ram_a

Behaviour:
- Clock and reset: clk; reset_n sampled at posedge clk only, synchronous active-low.
- Reset values:
  - Outputs: wait_n=1, cpu_q=0, vid_q=0, vid_ack=0, vid_ovf=0, ram_a=0, ram_d=0, ram_we=0.
  - Internal: state=IDLE; vid_pend, cpu_pend, cpu_done and starve_cnt cleared.
  - Reset mid-operation abandons the access: no write is issued and no ack is given.
- All outputs are registered.
- CPU strobe: cpu_act = !vdusel_n & (!rd_n | !wr_n).
  - If cpu_act & !cpu_done & !cpu_pend: set cpu_pend, latch cpu_a, cpu_d and type (write if wr_n low; write wins if both strobes are low), and drive wait_n=0 at the same edge.
  - cpu_done clears on the first cycle cpu_act=0. A still-active strobe after reset is treated as a new access.
- Video request: vid_req sets vid_pend and latches vid_a.
  - If vid_req arrives while vid_pend=1, or in the same cycle the previous fetch is granted, the new address overwrites the latch and vid_ovf=1 (sticky until reset).
- States: IDLE, VRD, VCAP, CRD, CCAP, CWR.
- IDLE arbitration (next-state decision):
  - vid_pend & !(cpu_pend & starve_cnt>=MAX_WAIT) -> VRD.
  - else cpu_pend & read -> CRD.
  - else cpu_pend & write -> CWR.
  - else stay in IDLE.
- Video fetch:
  - VRD: ram_a=vid address, clear vid_pend -> VCAP.
  - VCAP: vid_q<=ram_q, vid_ack=1 for exactly that one cycle -> IDLE.
- CPU read:
  - CRD: ram_a=cpu address -> CCAP.
  - CCAP: cpu_q<=ram_q, wait_n<=1, cpu_pend<=0, cpu_done<=1 -> IDLE.
- CPU write:
  - CWR: ram_a, ram_d=cpu_d, ram_we=1 for one cycle; wait_n<=1, cpu_pend<=0, cpu_done<=1 -> IDLE.
  - ram_we is never high in any other state.
- Latency from the grant decision to result: reads 3 cycles (ack/wait release registered at end of CAP), writes 2 cycles.
- Back-to-back services are spaced one access plus one IDLE cycle.
- starve_cnt (4 bit, saturating at 15):
  - Increments each cycle cpu_pend=1 and state is not CRD/CCAP/CWR.
  - Clears when a CPU grant is taken.
- wait_n is low exactly from the cpu_pend set edge until the completing edge.
- If the CPU drops its strobe while pending (illegal for Z80 with WAIT asserted), the access still completes.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks during an active write strobe -> all outputs at reset values, ram_we never 1; on release the write is performed once at the latched address, wait_n low then high.
- Video only: vid_req with vid_a=0x3FF, RAM[0x3FF]=0x41 -> ram_a=0x3FF one cycle after req; vid_ack pulses with vid_q=0x41 three cycles after req; vid_ovf stays 0.
- CPU only: write 0x55 to 0x123, then read 0x123 -> single ram_we pulse with ram_a=0x123, ram_d=0x55; read returns cpu_q=0x55; wait_n low 2 cycles (write) / 3 cycles (read).
- Contention: vid_req every 3 cycles and a CPU read pending -> video served first; once starve_cnt reaches 6 the CPU is granted; wait_n low no longer than 6+3 cycles; CPU grant never occurs before starve_cnt reaches 6.
- Overrun: two vid_req 1 cycle apart (0x010, 0x011) -> one vid_ack with RAM[0x011] data, vid_ovf=1 and remains 1 until reset.
- Strobe hold: CPU keeps rd_n low 10 cycles after wait_n releases -> exactly one RAM read, no second wait_n assertion; a new strobe after deassertion starts a fresh access.
